// File: rtl/ping_pong_reader_pkg.sv
// Shared types and default sizing for the ping-pong buffer read controller.
package ping_pong_rd_pkg;

    localparam int unsigned PP_WIDTH      = 16;
    localparam int unsigned PP_CHUNK_SIZE = 4;
    localparam int unsigned PP_NUM_CORES  = 2;
    localparam int unsigned PP_DEPTH      = 8;
    localparam int unsigned PP_NUM_PASSES = 2;

    // Counter width that stays at least one bit for degenerate sizes of 1.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

    localparam int unsigned PP_DATA_W = PP_WIDTH * PP_CHUNK_SIZE * PP_NUM_CORES;
    localparam int unsigned PP_ADDR_W = clog2_min1(PP_DEPTH);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN,
        RD_RELEASE
    } pp_rd_state_e;

endpackage

// File: rtl/ping_pong_reader_skid_buf.sv
// Two-entry bypass FIFO that absorbs buffer read data while the consumer stalls.
module pp_skid_buf
    import ping_pong_rd_pkg::*;
#(
    parameter int unsigned DW = PP_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          empty;
    logic          push;
    logic          pop;

    // An empty buffer passes incoming data straight through; storage is used only on stall.
    assign empty       = (count_q == 2'd0);
    assign out_valid_o = in_valid_i || !empty;
    assign out_data_o  = !empty    ? mem_q[rd_ptr_q] :
                         in_valid_i ? in_data_i       : '0;
    assign pop         = !empty && out_ready_i;
    assign push        = in_valid_i && !(empty && out_ready_i);
    assign count_o     = count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/ping_pong_reader.sv
// Read-side controller for a two-bank ping-pong buffer: replays each full bank
// NUM_PASSES times over a ready/valid stream, then hands it back to the writer.
module ping_pong_reader
    import ping_pong_rd_pkg::*;
#(
    parameter  int unsigned WIDTH      = PP_WIDTH,
    parameter  int unsigned CHUNK_SIZE = PP_CHUNK_SIZE,
    parameter  int unsigned NUM_CORES  = PP_NUM_CORES,
    parameter  int unsigned DEPTH      = PP_DEPTH,
    parameter  int unsigned NUM_PASSES = PP_NUM_PASSES,
    localparam int unsigned DATA_W     = WIDTH * CHUNK_SIZE * NUM_CORES,
    localparam int unsigned ADDR_W     = clog2_min1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        bank_full,
    output logic [1:0]        bank_release,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned PASS_W = clog2_min1(NUM_PASSES);
    localparam int unsigned TOTAL  = DEPTH * NUM_PASSES;
    localparam int unsigned CNT_W  = clog2_min1(TOTAL);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);

    pp_rd_state_e      state_q, state_d;
    logic              cur_bank_q, cur_bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              issue_last_q, issue_last_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_vld_q;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]        release_q, release_d;
    logic              busy_q;

    logic              skid_valid;
    logic [1:0]        skid_cnt;
    logic [2:0]        skid_cnt_nxt;
    logic              accept;
    logic              last_word;
    logic              room;
    logic              issue;

    pp_skid_buf #(
        .DW (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (rd_vld_q),
        .in_data_i   (rd_data),
        .out_valid_o (skid_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .count_o     (skid_cnt)
    );

    assign accept    = skid_valid && out_ready;
    assign last_word = skid_valid && (out_cnt_q == CNT_LAST);

    // Held words after this edge plus the read already on the bus must leave room for one more.
    assign skid_cnt_nxt = 3'(skid_cnt) + 3'(rd_vld_q) - 3'(accept);
    assign room         = (skid_cnt_nxt + 3'(rd_en_q)) < 3'd2;

    always_comb begin
        state_d      = state_q;
        cur_bank_d   = cur_bank_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        issue_last_d = issue_last_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        out_cnt_d    = out_cnt_q;
        release_d    = 2'b00;
        issue        = 1'b0;

        if (accept) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            RD_IDLE: begin
                if (bank_full[cur_bank_q]) begin
                    state_d = RD_READ;
                    issue   = 1'b1;
                end
            end
            RD_READ: begin
                if (issue_last_q) begin
                    state_d = RD_DRAIN;
                end else begin
                    issue = room;
                end
            end
            RD_DRAIN: begin
                if (accept && last_word) begin
                    state_d               = RD_RELEASE;
                    release_d[cur_bank_q] = 1'b1;
                end
            end
            RD_RELEASE: begin
                state_d      = RD_IDLE;
                cur_bank_d   = ~cur_bank_q;
                addr_d       = '0;
                pass_d       = '0;
                issue_last_d = 1'b0;
                out_cnt_d    = '0;
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase

        // Pass-major, address-minor walk; the pass counter holds once on its final value.
        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_q;
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                if (pass_q == PASS_LAST) begin
                    issue_last_d = 1'b1;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            cur_bank_q   <= 1'b0;
            addr_q       <= '0;
            pass_q       <= '0;
            issue_last_q <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            rd_vld_q     <= 1'b0;
            out_cnt_q    <= '0;
            release_q    <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_bank_q   <= cur_bank_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            issue_last_q <= issue_last_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_vld_q     <= rd_en_q;
            out_cnt_q    <= out_cnt_d;
            release_q    <= release_d;
            busy_q       <= (state_d != RD_IDLE);
        end
    end

    assign bank_release = release_q;
    assign rd_en        = rd_en_q;
    assign rd_bank      = cur_bank_q;
    assign rd_addr      = rd_addr_q;
    assign out_valid    = skid_valid;
    assign out_last     = last_word;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ping_pong_reader.sv
// Directed bench for ping_pong_reader: an 8x2 instance and a 1x1 degenerate instance.
module tb_ping_pong_reader;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PASSES = 2;
    localparam int unsigned TOTAL  = DEPTH * PASSES;
    localparam int unsigned DATA_W = 128;

    logic              clk;
    logic              rst_n;

    logic [1:0]        bank_full, bank_release;
    logic              rd_en, rd_bank;
    logic [2:0]        rd_addr;
    logic [DATA_W-1:0] rd_data, out_data;
    logic              out_valid, out_ready, out_last, busy;

    logic [1:0]        bank_full1, bank_release1;
    logic              rd_en1, rd_bank1;
    logic [0:0]        rd_addr1;
    logic [DATA_W-1:0] rd_data1, out_data1;
    logic              out_valid1, out_ready1, out_last1, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    ping_pong_reader #(.DEPTH(DEPTH), .NUM_PASSES(PASSES)) dut (
        .clk(clk), .rst_n(rst_n), .bank_full(bank_full), .bank_release(bank_release),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    ping_pong_reader #(.DEPTH(1), .NUM_PASSES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bank_full(bank_full1), .bank_release(bank_release1),
        .rd_en(rd_en1), .rd_bank(rd_bank1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read buffer models: bank 0 word a = a, bank 1 word a = 100 + a (8x2);
    // 200 + 100*bank + a for the degenerate instance.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= DATA_W'(rd_bank ? 100 + int'(rd_addr) : int'(rd_addr));
        if (rd_en1) rd_data1 <= DATA_W'(200 + (rd_bank1 ? 100 : 0) + int'(rd_addr1));
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_word(input int bank, input int k);
        return 128'((bank != 0 ? 100 : 0) + (k % DEPTH));
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_release"}, 128'(bank_release), 128'd0);
        check({tag, "_rd_en"}, 128'(rd_en), 128'd0);
        check({tag, "_rd_addr"}, 128'(rd_addr), 128'd0);
        check({tag, "_rd_bank"}, 128'(rd_bank), 128'd0);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_out_data"}, out_data, 128'd0);
        check({tag, "_out_last"}, 128'(out_last), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        check({tag, "_release1"}, 128'(bank_release1), 128'd0);
        check({tag, "_out_valid1"}, 128'(out_valid1), 128'd0);
        check({tag, "_out_data1"}, out_data1, 128'd0);
        check({tag, "_busy1"}, 128'(busy1), 128'd0);
    endtask

    // Streams one bank of the 8x2 instance; cycle 1 is the first negedge after the call.
    task automatic stream_bank(input int bank, input int pct, input int n_stop,
                               output int first_c, output int last_c);
        int k = 0;
        int issued = 0;
        int c = 0;
        logic stall = 1'b0;
        logic [DATA_W-1:0] held = '0;
        first_c = -1;
        last_c  = -1;
        while (k < n_stop && c < 400) begin
            @(negedge clk);
            c++;
            out_ready = ($urandom_range(0, 99) < pct);
            check("no_early_release", 128'(bank_release), 128'd0);
            if (rd_en) begin
                check("rd_bank", 128'(rd_bank), 128'(bank));
                check("rd_addr", 128'(rd_addr), 128'(issued % DEPTH));
                issued++;
                check("rd_count_le_total", 128'(issued <= TOTAL), 128'd1);
                check("outstanding_le_2", 128'((issued - k) <= 2), 128'd1);
            end
            if (stall) begin
                check("stall_valid_hold", 128'(out_valid), 128'd1);
                check("stall_data_hold", out_data, held);
            end
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                if (out_ready) begin
                    check("out_data", out_data, exp_word(bank, k));
                    check("out_last", 128'(out_last), 128'(k == TOTAL - 1));
                    k++;
                    last_c = c;
                end
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
        check("word_count", 128'(k), 128'(n_stop));
    endtask

    task automatic expect_release(input string tag, input logic [1:0] bank_mask);
        @(negedge clk);
        check({tag, "_pulse"}, 128'(bank_release), 128'(bank_mask));
        check({tag, "_busy_in_release"}, 128'(busy), 128'd1);
        @(negedge clk);
        check({tag, "_pulse_end"}, 128'(bank_release), 128'd0);
        check({tag, "_busy_idle"}, 128'(busy), 128'd0);
    endtask

    initial begin
        int f, l;
        rst_n      = 1'b0;
        bank_full  = 2'b00;
        out_ready  = 1'b0;
        bank_full1 = 2'b00;
        out_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Only bank 1 full: reader must keep waiting on bank 0.
        rst_n     = 1'b1;
        bank_full = 2'b10;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("idle_rd_en", 128'(rd_en), 128'd0);
            check("idle_out_valid", 128'(out_valid), 128'd0);
            check("idle_busy", 128'(busy), 128'd0);
        end

        // Both full: bank 0 first, then bank 1.
        bank_full = 2'b11;
        stream_bank(0, 100, TOTAL, f, l);
        check("alt0_first_cycle", 128'(f), 128'd2);
        check("alt0_last_cycle", 128'(l), 128'd17);
        expect_release("alt0", 2'b01);
        stream_bank(1, 100, TOTAL, f, l);
        check("alt1_first_cycle", 128'(f), 128'd2);
        check("alt1_last_cycle", 128'(l), 128'd17);
        expect_release("alt1", 2'b10);

        // Basic stream on bank 0 only.
        bank_full = 2'b01;
        stream_bank(0, 100, TOTAL, f, l);
        check("basic_first_cycle", 128'(f), 128'd2);
        check("basic_last_cycle", 128'(l), 128'd17);
        expect_release("basic", 2'b01);

        // Backpressure with ~30% ready on bank 1.
        bank_full = 2'b10;
        stream_bank(1, 30, TOTAL, f, l);
        check("bp_first_cycle", 128'(f), 128'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 128'(bank_release), 128'b10);
        @(negedge clk);
        check("bp_release_end", 128'(bank_release), 128'd0);

        // Reset after five words, then a clean restart from bank 0 address 0.
        bank_full = 2'b01;
        stream_bank(0, 100, 5, f, l);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        @(negedge clk);
        check_zero("midrst2");
        rst_n = 1'b1;
        stream_bank(0, 100, TOTAL, f, l);
        check("restart_first_cycle", 128'(f), 128'd2);
        check("restart_last_cycle", 128'(l), 128'd17);
        expect_release("restart", 2'b01);
        bank_full = 2'b00;

        // Degenerate DEPTH=1, NUM_PASSES=1 instance.
        bank_full1 = 2'b01;
        out_ready1 = 1'b1;
        @(negedge clk);
        check("deg_rd_en", 128'(rd_en1), 128'd1);
        check("deg_no_valid_yet", 128'(out_valid1), 128'd0);
        check("deg_busy", 128'(busy1), 128'd1);
        @(negedge clk);
        check("deg_valid", 128'(out_valid1), 128'd1);
        check("deg_last", 128'(out_last1), 128'd1);
        check("deg_data", out_data1, 128'd200);
        @(negedge clk);
        check("deg_release", 128'(bank_release1), 128'b01);
        check("deg_valid_off", 128'(out_valid1), 128'd0);
        bank_full1 = 2'b10;
        out_ready1 = 1'b0;
        @(negedge clk);
        check("deg_release_end", 128'(bank_release1), 128'd0);
        check("deg_idle_busy", 128'(busy1), 128'd0);
        @(negedge clk);
        check("deg1_rd_en", 128'(rd_en1), 128'd1);
        check("deg1_rd_bank", 128'(rd_bank1), 128'd1);
        @(negedge clk);
        check("deg1_valid", 128'(out_valid1), 128'd1);
        check("deg1_last", 128'(out_last1), 128'd1);
        check("deg1_data", out_data1, 128'd300);
        @(negedge clk);
        check("deg1_stall_valid", 128'(out_valid1), 128'd1);
        check("deg1_stall_data", out_data1, 128'd300);
        check("deg1_no_release", 128'(bank_release1), 128'd0);
        out_ready1 = 1'b1;
        @(negedge clk);
        check("deg1_release", 128'(bank_release1), 128'b10);
        check("deg1_valid_off", 128'(out_valid1), 128'd0);
        @(negedge clk);
        check("deg1_release_end", 128'(bank_release1), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ping_pong_reader.md
Name: ping_pong_reader

Overview:
- Read-side controller for a two-bank ping-pong buffer (west or north) feeding the systolic Q·K^T stage.
- Waits until the writer marks a bank full, then streams that bank NUM_PASSES times with ready/valid backpressure.
- Releases the bank back to the writer, then moves to the other bank, strictly alternating 0,1,0,1,...
- Hides the buffer's 1-cycle synchronous read latency with an internal skid stage.

Parameters:
- WIDTH, 16, bits per element.
- CHUNK_SIZE, 4, elements per block chunk.
- NUM_CORES, 2, cores sharing one buffer word.
- DEPTH, 8, words per bank (W_COL_X*TOTAL_INPUT_W_W for west; N_ROW_X for north).
- NUM_PASSES, 2, times each bank is replayed (reuse factor, e.g. COL_SIZE_MAT_C_PP).
- DATA_W, WIDTH*CHUNK_SIZE*NUM_CORES (128), derived word width.
- ADDR_W, $clog2(DEPTH) (3), derived.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- bank_full  in  2  level per bank, set by writer when bank written, held until release
- bank_release  out  2  one-cycle pulse per bank when reader is done with it
- rd_en  out  1  buffer read strobe
- rd_bank  out  1  bank select for the read
- rd_addr  out  ADDR_W  word address within bank
- rd_data  in  DATA_W  buffer data, valid exactly 1 cycle after rd_en
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  stream word
- out_last  out  1  high with last word of the last pass of a bank
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; current bank 0; addr, pass counter and skid stage cleared. Reset mid-stream aborts without a release pulse.
- States:
  - IDLE -> READ when bank_full[cur_bank]=1. The other bank's flag is ignored.
  - READ issues rd_en with addr 0..DEPTH-1 for pass 0..NUM_PASSES-1 (pass-major, addr-minor). After the final address -> DRAIN.
  - DRAIN waits until the skid stage is empty and the last word has been accepted (out_valid&&out_ready) -> RELEASE.
  - RELEASE: bank_release[cur_bank]=1 for 1 cycle; toggle cur_bank; -> IDLE.
- Read issue rule: rd_en=1 only when in READ and skid occupancy plus in-flight read count is below 2. Guarantees no data loss under out_ready=0.
- Latency: first out_valid 2 cycles after bank_full is seen in IDLE (IDLE->READ 1 cycle, rd_data 1 cycle). With out_ready held 1, throughput is 1 word/cycle and there are no bubbles between passes.
- Word count: exactly DEPTH*NUM_PASSES words per bank; out_last on the final one only.
- Stream rules: out_data/out_valid hold stable while out_valid&&!out_ready.
- Counter wrap: addr wraps DEPTH-1 -> 0 and increments pass. The pass counter saturates at its final value.
- bank_full deasserting before release is a protocol error and is ignored; the reader finishes the bank.
- Both bank_full bits high: only cur_bank is served; after release the reader goes to IDLE and starts the other bank the next cycle, giving a 2-cycle gap total.
- DEPTH=1 and NUM_PASSES=1 must work: a single word with out_last=1.

Decomposition:
- Shared package ping_pong_rd_pkg: typedef for the state enum (IDLE, READ, DRAIN, RELEASE); DATA_W and ADDR_W derived from top_pkg widths/chunk size and the ping_pong_pkg depth constants.
- Sub-module pp_skid_buf: 2-entry DATA_W FIFO with in_valid, out_valid/out_ready and a count output, used by the read-issue rule.

Test Plan:
- Basic stream: DEPTH=8, NUM_PASSES=2, bank 0 word k=k, bank_full=01, out_ready=1 -> 16 words 0..7,0..7 on consecutive cycles, first at cycle+2; out_last on the 16th; bank_release=01 pulse for 1 cycle.
- Alternation: bank_full=11 from reset -> bank 0 streamed and released, then bank 1 (words 100..107 twice); never bank 1 first.
- Backpressure: random out_ready at 30% -> same 16-word sequence, no drops or duplicates; out_data stable while stalled; rd_en never issued with more than 2 words outstanding.
- Idle wait: bank_full=10 at start -> no rd_en or out_valid until the bank 0 flag rises; busy=0 throughout.
- Reset mid-stream: rst_n=0 after 5 words -> all outputs 0 next cycle, no bank_release; after reset with bank_full=01, restarts at bank 0 addr 0.
- Degenerate: DEPTH=1, NUM_PASSES=1 -> single word with out_valid and out_last together, release pulse 1 cycle after acceptance.
